// File: rtl/exp_kernel_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : exp_kernel_ram_ctrl_if
// Brief    : Loader / engine bundle for the expand-stage kernel store.
//            The slave modport is the kernel store, the master modport is
//            whoever drives it (loader plus expand convolution engine).
// Revision : 1.0 - initial release
// ============================================================================
interface exp_kernel_ram_ctrl_if #(
    parameter int DEPTH  = 128,
    parameter int KER3_W = 72,
    parameter int KER1_W = 32
);
    localparam int AW = $clog2(DEPTH);

    // layer configuration and load control
    logic              start_i;
    logic [AW-1:0]     one_exp_ker_addr_limit_i;
    logic              ker_wr_en_i;
    logic [2:0]        ker_wr_sel_i;
    logic [AW-1:0]     ker_wr_addr_i;
    logic [KER3_W-1:0] ker_wr_data_i;
    logic              load_done_i;

    // 3x3 read channel
    logic              exp_3x3_kerl_req_i;
    logic              exp_3x3_kerl_ready_o;
    logic [KER3_W-1:0] exp_3x3_kerl_1_data_o;
    logic [KER3_W-1:0] exp_3x3_kerl_2_data_o;
    logic [KER3_W-1:0] exp_3x3_kerl_3_data_o;
    logic [KER3_W-1:0] exp_3x3_kerl_4_data_o;

    // 1x1 read channel
    logic              exp_1x1_kerl_req_i;
    logic              exp_1x1_kerl_ready_o;
    logic [KER1_W-1:0] exp_1x1_kerl_data_o;

    // status
    logic [15:0]       sweep_count_o;

    modport slave (
        input  start_i, one_exp_ker_addr_limit_i,
        input  ker_wr_en_i, ker_wr_sel_i, ker_wr_addr_i, ker_wr_data_i, load_done_i,
        input  exp_3x3_kerl_req_i,
        output exp_3x3_kerl_ready_o,
        output exp_3x3_kerl_1_data_o, exp_3x3_kerl_2_data_o,
        output exp_3x3_kerl_3_data_o, exp_3x3_kerl_4_data_o,
        input  exp_1x1_kerl_req_i,
        output exp_1x1_kerl_ready_o, exp_1x1_kerl_data_o,
        output sweep_count_o
    );

    modport master (
        output start_i, one_exp_ker_addr_limit_i,
        output ker_wr_en_i, ker_wr_sel_i, ker_wr_addr_i, ker_wr_data_i, load_done_i,
        output exp_3x3_kerl_req_i,
        input  exp_3x3_kerl_ready_o,
        input  exp_3x3_kerl_1_data_o, exp_3x3_kerl_2_data_o,
        input  exp_3x3_kerl_3_data_o, exp_3x3_kerl_4_data_o,
        output exp_1x1_kerl_req_i,
        input  exp_1x1_kerl_ready_o, exp_1x1_kerl_data_o,
        input  sweep_count_o
    );
endinterface
`default_nettype wire

// File: rtl/exp_kernel_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exp_kernel_ram_ctrl
// Brief    : Kernel storage for the expand stage. Four 3x3 banks and one
//            1x1 bank are filled during LOAD and read back during SERVE with
//            a one-cycle-latency req/ready handshake. Read addresses sweep
//            0..limit-1 and wrap so one kernel set serves every pixel.
// Revision : 1.0 - initial release
// ============================================================================
module exp_kernel_ram_ctrl #(
    parameter int DEPTH  = 128,
    parameter int KER3_W = 72,
    parameter int KER1_W = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_n_i,
    exp_kernel_ram_ctrl_if.slave  bus
);
    localparam int AW      = $clog2(DEPTH);
    localparam int N_BANK3 = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    state_t                              r_state_q,  w_state_d;
    logic                                r_ready_q,  w_ready_d;
    logic [AW-1:0]                       r_limit_q,  w_limit_d;
    logic [AW-1:0]                       r_addr3_q,  w_addr3_d;
    logic [AW-1:0]                       r_addr1_q,  w_addr1_d;
    logic [15:0]                         r_sweep_q,  w_sweep_d;
    logic [N_BANK3-1:0][KER3_W-1:0]      r_data3_q,  w_data3_d;
    logic [KER1_W-1:0]                   r_data1_q,  w_data1_d;

    logic [N_BANK3-1:0][KER3_W-1:0]      w_rd3;
    logic [KER1_W-1:0]                   w_rd1;
    logic                                w_wr_ok;
    logic                                w_acc3;
    logic                                w_acc1;
    logic [AW-1:0]                       w_last;

    // Reset also blocks writes so nothing lands in memory while rst_n_i is low
    assign w_wr_ok = rst_n_i && bus.ker_wr_en_i && (r_state_q == ST_LOAD);

    // One storage array per 3x3 bank; the read port follows the live address
    for (genvar b = 0; b < N_BANK3; b++) begin : g_bank3
        logic [KER3_W-1:0] r_mem [DEPTH];

        // Loader write into this bank
        always_ff @(posedge clk_i) begin
            if (w_wr_ok && (bus.ker_wr_sel_i == 3'(b))) begin
                r_mem[bus.ker_wr_addr_i] <= bus.ker_wr_data_i;
            end
        end

        assign w_rd3[b] = r_mem[r_addr3_q];
    end

    logic [KER1_W-1:0] r_mem1 [DEPTH];

    // Loader write into the 1x1 bank (low bits of the write bus)
    always_ff @(posedge clk_i) begin
        if (w_wr_ok && (bus.ker_wr_sel_i == 3'd4)) begin
            r_mem1[bus.ker_wr_addr_i] <= bus.ker_wr_data_i[KER1_W-1:0];
        end
    end

    assign w_rd1 = r_mem1[r_addr1_q];

    // Next-state logic: phase control, handshake acceptance, address sweep
    always_comb begin
        w_state_d = r_state_q;
        w_limit_d = r_limit_q;
        w_addr3_d = r_addr3_q;
        w_addr1_d = r_addr1_q;
        w_sweep_d = r_sweep_q;
        w_data3_d = r_data3_q;
        w_data1_d = r_data1_q;

        // A zero limit behaves as a one-word sweep
        w_last = (r_limit_q == '0) ? '0 : r_limit_q - 1'b1;

        // start_i discards any request that coincides with it
        w_acc3 = bus.exp_3x3_kerl_req_i && r_ready_q && !bus.start_i;
        w_acc1 = bus.exp_1x1_kerl_req_i && r_ready_q && !bus.start_i;

        if (w_acc3) begin
            w_data3_d = w_rd3;
            if (r_addr3_q >= w_last) begin
                w_addr3_d = '0;
                if (r_sweep_q != 16'hFFFF) begin
                    w_sweep_d = r_sweep_q + 16'd1;
                end
            end else begin
                w_addr3_d = r_addr3_q + 1'b1;
            end
        end

        if (w_acc1) begin
            w_data1_d = w_rd1;
            w_addr1_d = (r_addr1_q >= w_last) ? '0 : r_addr1_q + 1'b1;
        end

        if (bus.start_i) begin
            w_state_d = ST_LOAD;
            w_limit_d = bus.one_exp_ker_addr_limit_i;
            w_addr3_d = '0;
            w_addr1_d = '0;
            w_sweep_d = '0;
        end else if ((r_state_q == ST_LOAD) && bus.load_done_i) begin
            w_state_d = ST_SERVE;
        end

        w_ready_d = (w_state_d == ST_SERVE);
    end

    // State register with synchronous active-low reset; memories are untouched
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state_q <= ST_IDLE;
            r_ready_q <= 1'b0;
            r_limit_q <= '0;
            r_addr3_q <= '0;
            r_addr1_q <= '0;
            r_sweep_q <= '0;
            r_data3_q <= '0;
            r_data1_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_ready_q <= w_ready_d;
            r_limit_q <= w_limit_d;
            r_addr3_q <= w_addr3_d;
            r_addr1_q <= w_addr1_d;
            r_sweep_q <= w_sweep_d;
            r_data3_q <= w_data3_d;
            r_data1_q <= w_data1_d;
        end
    end

    assign bus.exp_3x3_kerl_ready_o  = r_ready_q;
    assign bus.exp_1x1_kerl_ready_o  = r_ready_q;
    assign bus.exp_3x3_kerl_1_data_o = r_data3_q[0];
    assign bus.exp_3x3_kerl_2_data_o = r_data3_q[1];
    assign bus.exp_3x3_kerl_3_data_o = r_data3_q[2];
    assign bus.exp_3x3_kerl_4_data_o = r_data3_q[3];
    assign bus.exp_1x1_kerl_data_o   = r_data1_q;
    assign bus.sweep_count_o         = r_sweep_q;

endmodule
`default_nettype wire
